traffic_conflict_monitor: RTL and testbench



---
 rtl/traffic_conflict_monitor.sv | 214 +++++++++++++++++++++
 tb/tb_traffic_conflict_monitor.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/traffic_conflict_monitor.sv
// -----------------------------------------------------------------------------
// traffic_conflict_monitor
//
// Safety stage placed between the traffic light controller and the lamp
// drivers. Each cycle it checks the four direction lamp codes for illegal
// encodings, conflicting right-of-way, and yellow phases that were skipped or
// too short. Clean codes pass through with one register of latency. A
// confirmed fault latches a flashing all-red lockout that stays until an
// operator clear arrives with clean inputs. The clear is followed by a solid
// all-red recovery period.
//
// Ports
//   clk, rst                         clock (rising edge), async active-high reset
//   n/s/e/w_light_in [2:0]           lamp codes from the controller
//   fault_clr                        operator clear, sampled every cycle
//   n/s/e/w_light    [2:0]           registered lamp drive
//   fault                            high while in lockout
//   fault_code       [1:0]           last confirmed cause: 1 illegal, 2 conflict,
//                                    3 yellow violation
//   conflict_cnt     [7:0]           confirmed-fault count, saturates at 255
// -----------------------------------------------------------------------------
module traffic_conflict_monitor #(
    parameter int FILTER_CYCLES  = 2,
    parameter int FLASH_HALF     = 4,
    parameter int MIN_YELLOW     = 2,
    parameter int RECOVER_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] n_light_in,
    input  logic [2:0] s_light_in,
    input  logic [2:0] e_light_in,
    input  logic [2:0] w_light_in,
    input  logic       fault_clr,
    output logic [2:0] n_light,
    output logic [2:0] s_light,
    output logic [2:0] e_light,
    output logic [2:0] w_light,
    output logic       fault,
    output logic [1:0] fault_code,
    output logic [7:0] conflict_cnt
);

    localparam logic [2:0] LAMP_G   = 3'b001;
    localparam logic [2:0] LAMP_Y   = 3'b010;
    localparam logic [2:0] LAMP_R   = 3'b100;
    localparam logic [2:0] LAMP_OFF = 3'b000;

    localparam int FILT_W  = $clog2(FILTER_CYCLES + 1);
    localparam int FLASH_W = $clog2(2 * FLASH_HALF);
    localparam int REC_W   = $clog2(RECOVER_CYCLES + 1);
    localparam int YEL_W   = $clog2(MIN_YELLOW + 1);

    typedef enum logic [1:0] {ST_PASS, ST_CHECK, ST_LOCKOUT, ST_RECOVER} state_t;

    state_t               state_reg, state_next;
    logic [FILT_W-1:0]    filt_reg, filt_next;
    logic [FLASH_W-1:0]   flash_reg, flash_next;
    logic [REC_W-1:0]     rec_reg, rec_next;
    logic [1:0]           code_reg;
    logic [7:0]           cnt_reg;
    logic                 enter_lock;
    logic [1:0]           enter_code;

    // Index 0..3 = N, S, E, W.
    logic [2:0]           lamp_in [4];
    logic [2:0]           lamp_reg [4];
    logic [2:0]           lamp_next [4];
    logic [2:0]           prev_reg [4];
    logic [YEL_W-1:0]     run_reg [4];
    logic [3:0]           legal;
    logic [3:0]           non_red;
    logic [3:0]           yel_dir;

    logic                 illegal, conflict, level_viol, yel_viol;
    logic [1:0]           level_code;

    assign lamp_in[0] = n_light_in;
    assign lamp_in[1] = s_light_in;
    assign lamp_in[2] = e_light_in;
    assign lamp_in[3] = w_light_in;

    // Per-direction classification plus yellow history. The history runs in
    // every state so that the first PASS cycle after recovery already has a
    // valid previous code.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_dir
            assign legal[gi]   = (lamp_in[gi] == LAMP_G) || (lamp_in[gi] == LAMP_Y) ||
                                 (lamp_in[gi] == LAMP_R);
            assign non_red[gi] = (lamp_in[gi] == LAMP_G) || (lamp_in[gi] == LAMP_Y);
            // Red straight after green, or red after a yellow run that was too short.
            assign yel_dir[gi] = (lamp_in[gi] == LAMP_R) &&
                                 ((prev_reg[gi] == LAMP_G) ||
                                  ((prev_reg[gi] == LAMP_Y) &&
                                   (run_reg[gi] < YEL_W'(MIN_YELLOW))));

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    prev_reg[gi] <= LAMP_OFF;
                    run_reg[gi]  <= '0;
                end else begin
                    prev_reg[gi] <= lamp_in[gi];
                    if (lamp_in[gi] != LAMP_Y)
                        run_reg[gi] <= '0;
                    else if (run_reg[gi] != YEL_W'(MIN_YELLOW))
                        run_reg[gi] <= run_reg[gi] + YEL_W'(1);
                end
            end
        end
    endgenerate

    assign illegal    = ~&legal;
    assign conflict   = (non_red[0] | non_red[1]) & (non_red[2] | non_red[3]);
    assign level_viol = illegal | conflict;
    assign level_code = illegal ? 2'd1 : 2'd2;
    assign yel_viol   = |yel_dir;

    // State register and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_RECOVER;
            filt_reg  <= '0;
            flash_reg <= '0;
            rec_reg   <= '0;
            code_reg  <= 2'd0;
            cnt_reg   <= 8'd0;
            for (int i = 0; i < 4; i++) lamp_reg[i] <= LAMP_R;
        end else begin
            state_reg <= state_next;
            filt_reg  <= filt_next;
            flash_reg <= flash_next;
            rec_reg   <= rec_next;
            for (int i = 0; i < 4; i++) lamp_reg[i] <= lamp_next[i];
            if (enter_lock) begin
                code_reg <= enter_code;
                if (cnt_reg != 8'hFF) cnt_reg <= cnt_reg + 8'd1;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        filt_next  = filt_reg;
        flash_next = '0;
        rec_next   = '0;
        enter_lock = 1'b0;
        enter_code = level_code;
        case (state_reg)
            ST_PASS: begin
                if (yel_viol) begin
                    state_next = ST_LOCKOUT;
                    enter_lock = 1'b1;
                    enter_code = 2'd3;
                end else if (level_viol) begin
                    if (FILTER_CYCLES == 1) begin
                        state_next = ST_LOCKOUT;
                        enter_lock = 1'b1;
                    end else begin
                        state_next = ST_CHECK;
                        filt_next  = FILT_W'(1);
                    end
                end
            end
            ST_CHECK: begin
                if (!level_viol) begin
                    state_next = ST_PASS;
                end else if (filt_reg + FILT_W'(1) == FILT_W'(FILTER_CYCLES)) begin
                    state_next = ST_LOCKOUT;
                    enter_lock = 1'b1;
                end else begin
                    filt_next = filt_reg + FILT_W'(1);
                end
            end
            ST_LOCKOUT: begin
                if (fault_clr && !level_viol) begin
                    state_next = ST_RECOVER;
                end else if (flash_reg != FLASH_W'(2 * FLASH_HALF - 1)) begin
                    flash_next = flash_reg + FLASH_W'(1);
                end
            end
            default: begin // ST_RECOVER
                if (level_viol)
                    rec_next = '0;
                else if (rec_reg == REC_W'(RECOVER_CYCLES - 1))
                    state_next = ST_PASS;
                else
                    rec_next = rec_reg + REC_W'(1);
            end
        endcase
    end

    // Output logic: lamp register next value follows the state being entered.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            lamp_next[i] = LAMP_R;
            case (state_next)
                ST_PASS:    lamp_next[i] = lamp_in[i];
                ST_LOCKOUT: lamp_next[i] = (flash_next < FLASH_W'(FLASH_HALF)) ? LAMP_R : LAMP_OFF;
                default:    lamp_next[i] = LAMP_R;
            endcase
        end
    end

    assign fault        = (state_reg == ST_LOCKOUT);
    assign fault_code   = code_reg;
    assign conflict_cnt = cnt_reg;
    assign n_light      = lamp_reg[0];
    assign s_light      = lamp_reg[1];
    assign e_light      = lamp_reg[2];
    assign w_light      = lamp_reg[3];

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// -----------------------------------------------------------------------------
// Directed testbench for traffic_conflict_monitor (default parameters).
// Expected outputs are pushed to a scoreboard queue as each stimulus step is
// driven and popped/compared one time unit after the clock edge.
// -----------------------------------------------------------------------------
module tb_traffic_conflict_monitor;

    localparam int FH    = 4;
    localparam int R_CYC = 8;

    localparam logic [2:0] G = 3'b001;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] BAD = 3'b011;

    localparam logic [11:0] CLEAN = {G, G, R, R};
    localparam logic [11:0] ALLR  = {R, R, R, R};
    localparam logic [11:0] CONF  = {G, G, G, R};
    localparam logic [11:0] DARK  = 12'h000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] n_in, s_in, e_in, w_in;
    logic       fault_clr;
    logic [2:0] n_light, s_light, e_light, w_light;
    logic       fault;
    logic [1:0] fault_code;
    logic [7:0] conflict_cnt;

    always #5 clk = ~clk;

    traffic_conflict_monitor dut (
        .clk          (clk),
        .rst          (rst),
        .n_light_in   (n_in),
        .s_light_in   (s_in),
        .e_light_in   (e_in),
        .w_light_in   (w_in),
        .fault_clr    (fault_clr),
        .n_light      (n_light),
        .s_light      (s_light),
        .e_light      (e_light),
        .w_light      (w_light),
        .fault        (fault),
        .fault_code   (fault_code),
        .conflict_cnt (conflict_cnt)
    );

    typedef struct packed {
        logic [11:0] lamps;
        logic        flt;
        logic [1:0]  code;
        logic [7:0]  cnt;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    n_asserts = 0;
    int    n_fails   = 0;
    logic [1:0] exp_code = 2'd0;
    logic [7:0] exp_cnt  = 8'd0;

    task automatic push_exp(input string tag, input logic [11:0] lamps, input logic flt);
        exp_t e;
        e.lamps = lamps;
        e.flt   = flt;
        e.code  = exp_code;
        e.cnt   = exp_cnt;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic check_front();
        exp_t        e;
        string       tag;
        logic [11:0] obs;
        e   = exp_q.pop_front();
        tag = tag_q.pop_front();
        obs = {n_light, s_light, e_light, w_light};
        n_asserts++;
        assert (obs === e.lamps) else begin
            n_fails++;
            $error("FAIL %s lamps: observed %b expected %b", tag, obs, e.lamps);
        end
        n_asserts++;
        assert (fault === e.flt) else begin
            n_fails++;
            $error("FAIL %s fault: observed %b expected %b", tag, fault, e.flt);
        end
        n_asserts++;
        assert (fault_code === e.code) else begin
            n_fails++;
            $error("FAIL %s fault_code: observed %0d expected %0d", tag, fault_code, e.code);
        end
        n_asserts++;
        assert (conflict_cnt === e.cnt) else begin
            n_fails++;
            $error("FAIL %s conflict_cnt: observed %0d expected %0d", tag, conflict_cnt, e.cnt);
        end
    endtask

    task automatic check_now(input string tag, input logic [11:0] lamps, input logic flt);
        push_exp(tag, lamps, flt);
        check_front();
    endtask

    // Drive one cycle of inputs, then compare one time unit after the edge.
    task automatic step(input string tag, input logic [11:0] lin, input logic clr,
                        input logic [11:0] lamps, input logic flt);
        {n_in, s_in, e_in, w_in} = lin;
        fault_clr = clr;
        push_exp(tag, lamps, flt);
        @(posedge clk);
        #1;
        check_front();
    endtask

    task automatic lock_enter(input string tag, input logic [11:0] lin, input logic [1:0] code);
        exp_code = code;
        if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
        step(tag, lin, 1'b0, ALLR, 1'b1);
    endtask

    // Lockout cycles numbered p from the entry edge (p = 0 at entry).
    task automatic lockout_run(input string tag, input logic [11:0] lin, input logic clr,
                               input int n, input int start_p);
        for (int i = 0; i < n; i++) begin
            int p;
            p = start_p + i;
            step(tag, lin, clr, ((p % (2 * FH)) < FH) ? ALLR : DARK, 1'b1);
        end
    endtask

    task automatic recover_run(input string tag, input logic [11:0] lin);
        for (int i = 0; i < R_CYC - 1; i++) step(tag, lin, 1'b0, ALLR, 1'b0);
        step(tag, lin, 1'b0, lin, 1'b0);
    endtask

    task automatic clear_and_recover(input string tag);
        step(tag, CLEAN, 1'b1, ALLR, 1'b0);
        recover_run(tag, CLEAN);
    endtask

    initial begin
        {n_in, s_in, e_in, w_in} = CLEAN;
        fault_clr = 1'b0;

        // Reset, then clean pass-through after the recovery period.
        #1 rst = 1'b1;
        #2 check_now("reset_async", ALLR, 1'b0);
        @(posedge clk); #1 check_now("reset_hold", ALLR, 1'b0);
        @(posedge clk); #1 check_now("reset_hold2", ALLR, 1'b0);
        #2 rst = 1'b0;
        recover_run("reset_release", CLEAN);
        step("pass_clean", CLEAN, 1'b0, CLEAN, 1'b0);

        // One-cycle conflict glitch is filtered out.
        step("glitch_check", CONF, 1'b0, ALLR, 1'b0);
        step("glitch_back", CLEAN, 1'b0, CLEAN, 1'b0);
        step("glitch_pass", CLEAN, 1'b0, CLEAN, 1'b0);

        // Held conflict: lockout, flash pattern, clear ignored during violation.
        step("conf_check", CONF, 1'b0, ALLR, 1'b0);
        lock_enter("conf_lock", CONF, 2'd2);
        lockout_run("conf_flash", CONF, 1'b0, 3, 1);
        lockout_run("conf_clr_ignored", CONF, 1'b1, 1, 4);
        lockout_run("conf_flash2", CONF, 1'b0, 5, 5);
        clear_and_recover("conf_clear");

        // Illegal code on W.
        step("illegal_check", {G, G, R, BAD}, 1'b0, ALLR, 1'b0);
        lock_enter("illegal_lock", {G, G, R, BAD}, 2'd1);
        clear_and_recover("illegal_clear");

        // Illegal together with conflict still reports illegal.
        step("both_check", {G, G, G, BAD}, 1'b0, ALLR, 1'b0);
        lock_enter("both_lock", {G, G, G, BAD}, 2'd1);
        clear_and_recover("both_clear");

        // Green straight to red.
        lock_enter("yel_skip", {R, G, R, R}, 2'd3);
        clear_and_recover("yel_skip_clear");

        // Yellow for one cycle only.
        step("yel_short_y", {Y, G, R, R}, 1'b0, {Y, G, R, R}, 1'b0);
        lock_enter("yel_short_r", {R, G, R, R}, 2'd3);
        clear_and_recover("yel_short_clear");

        // Yellow for the minimum two cycles is accepted.
        step("yel_ok_y1", {Y, G, R, R}, 1'b0, {Y, G, R, R}, 1'b0);
        step("yel_ok_y2", {Y, G, R, R}, 1'b0, {Y, G, R, R}, 1'b0);
        step("yel_ok_r", {R, G, R, R}, 1'b0, {R, G, R, R}, 1'b0);
        step("yel_ok_g", CLEAN, 1'b0, CLEAN, 1'b0);

        // Many faults: counter saturates at 255.
        for (int k = 0; k < 252; k++) begin
            lock_enter("sat_lock", {R, G, R, R}, 2'd3);
            clear_and_recover("sat_clear");
        end

        // Reset during a flash-off phase.
        step("mid_check", CONF, 1'b0, ALLR, 1'b0);
        lock_enter("mid_lock", CONF, 2'd2);
        lockout_run("mid_flash", CONF, 1'b0, 4, 1);
        {n_in, s_in, e_in, w_in} = CLEAN;
        #2 rst = 1'b1;
        exp_code = 2'd0;
        exp_cnt  = 8'd0;
        #1 check_now("reset_mid_lockout", ALLR, 1'b0);
        #3 rst = 1'b0;
        recover_run("post_reset", CLEAN);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
